// File: rtl/readout_pulse_gen.sv
// readout_pulse_gen
//   Plays one I/Q readout tone per start request. The request fields are
//   latched when start is accepted. After delay_cycles idle cycles the block
//   emits pulse_length cycles of samples. Each cycle carries five time-ordered
//   lanes per quadrature, generated from a 64-entry sine table and scaled by
//   amplitude.
//
//   Optional build macro: PULSE_GEN_RAMP_EN adds a linear rise/fall envelope
//   of 2^RAMP_SHIFT cycles on each edge of the pulse. When the macro is
//   undefined the envelope is rectangular.
//
// Ports
//   clk100                   sole clock, rising edge
//   reset                    synchronous, active-high
//   start                    single-cycle play request (ignored while busy)
//   pulse_length[10:0]       number of valid output cycles
//   delay_cycles[9:0]        idle cycles before playback
//   freq_step[5:0]           phase step per sample, 1/64 turn units
//   amplitude[14:0]          unsigned peak amplitude
//   busy                     request accepted and not yet done
//   trig_out                 one-cycle marker on the first valid sample
//   samples_valid            data outputs carry samples
//   data0_out_0..4           signed I lanes, lane 0 earliest
//   data1_out_0..4           signed Q lanes, lane 0 earliest
//   done                     one-cycle pulse after the last valid sample
module readout_pulse_gen #(
    parameter int unsigned RAMP_SHIFT = 3
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] pulse_length,
    input  logic [9:0]  delay_cycles,
    input  logic [5:0]  freq_step,
    input  logic [14:0] amplitude,
    output logic        busy,
    output logic        trig_out,
    output logic        samples_valid,
    output logic [15:0] data0_out_0,
    output logic [15:0] data0_out_1,
    output logic [15:0] data0_out_2,
    output logic [15:0] data0_out_3,
    output logic [15:0] data0_out_4,
    output logic [15:0] data1_out_0,
    output logic [15:0] data1_out_1,
    output logic [15:0] data1_out_2,
    output logic [15:0] data1_out_3,
    output logic [15:0] data1_out_4,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DELAY, PLAY, FINISH} state_t;

    state_t             state_q, state_d;
    logic        [10:0] cnt_q, cnt_d;
    logic        [10:0] len_q, len_d;
    logic        [5:0]  step_q, step_d;
    logic        [14:0] amp_q, amp_d;
    logic        [5:0]  base_q, base_d;
    logic               valid_q, trig_q, done_q;
    logic signed [15:0] i_q [5];
    logic signed [15:0] q_q [5];
    logic signed [15:0] i_d [5];
    logic signed [15:0] q_d [5];
    logic        [5:0]  lane_ph [5];
    logic               play;

    // First quadrant of a full-scale (32767) sine, 16 steps per quarter turn.
    function automatic logic signed [15:0] quarter_sin(input logic [4:0] idx);
        case (idx)
            5'd0:    return 16'sd0;
            5'd1:    return 16'sd3212;
            5'd2:    return 16'sd6393;
            5'd3:    return 16'sd9512;
            5'd4:    return 16'sd12539;
            5'd5:    return 16'sd15446;
            5'd6:    return 16'sd18204;
            5'd7:    return 16'sd20787;
            5'd8:    return 16'sd23170;
            5'd9:    return 16'sd25329;
            5'd10:   return 16'sd27245;
            5'd11:   return 16'sd28898;
            5'd12:   return 16'sd30273;
            5'd13:   return 16'sd31356;
            5'd14:   return 16'sd32137;
            5'd15:   return 16'sd32609;
            default: return 16'sd32767;
        endcase
    endfunction

    // Full 64-entry sine built from the quarter wave by symmetry.
    function automatic logic signed [15:0] sin_lut(input logic [5:0] ph);
        logic [4:0] fwd, rev;
        fwd = {1'b0, ph[3:0]};
        rev = 5'd16 - fwd;
        case (ph[5:4])
            2'd0:    return quarter_sin(fwd);
            2'd1:    return quarter_sin(rev);
            2'd2:    return -quarter_sin(fwd);
            default: return -quarter_sin(rev);
        endcase
    endfunction

    // amplitude * table value, arithmetic shift by 15, keep the low 16 bits.
    function automatic logic signed [15:0] scale_sample(input logic [14:0] amp,
                                                        input logic signed [15:0] lut);
        logic signed [31:0] prod;
        prod = $signed({17'd0, amp}) * 32'(lut);
        return 16'(prod >>> 15);
    endfunction

    assign play = (state_q == PLAY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        step_d  = step_q;
        amp_d   = amp_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = pulse_length;
                    step_d = freq_step;
                    amp_d  = amplitude;
                    base_d = '0;
                    if (delay_cycles != '0) begin
                        state_d = DELAY;
                        cnt_d   = {1'b0, delay_cycles};
                    end else if (pulse_length != '0) begin
                        state_d = PLAY;
                        cnt_d   = pulse_length;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == 11'd1) begin
                    if (len_q != '0) begin
                        state_d = PLAY;
                        cnt_d   = len_q;
                    end else begin
                        state_d = FINISH;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
            PLAY: begin
                // Five samples per cycle, so the base moves by 5 steps.
                base_d = base_q + step_q + (step_q << 2);
                cnt_d  = cnt_q - 11'd1;
                if (cnt_q == 11'd1) begin
                    state_d = FINISH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PULSE_GEN_RAMP_EN
    localparam logic [11:0] RAMP_TOP = 12'(1 << RAMP_SHIFT);

    logic [11:0] ramp_s;

    // cnt_q runs pulse_length..1 during PLAY, so it is also the remaining
    // count, and pulse_length - cnt_q is the 0-based cycle index.
    always_comb begin
        logic [11:0] rise, fall;
        rise   = {1'b0, len_q - cnt_q} + 12'd1;
        fall   = {1'b0, cnt_q};
        ramp_s = (rise < fall) ? rise : fall;
        if (RAMP_TOP < ramp_s) begin
            ramp_s = RAMP_TOP;
        end
    end

    function automatic logic signed [15:0] apply_ramp(input logic signed [15:0] x,
                                                      input logic [11:0] s);
        logic signed [31:0] prod;
        prod = 32'(x) * $signed({20'd0, s});
        return 16'(prod >>> RAMP_SHIFT);
    endfunction
`else
    logic [31:0] unused_ramp_shift;
    assign unused_ramp_shift = 32'(RAMP_SHIFT);
`endif

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            lane_ph[k] = base_q + 6'(k) * step_q;
`ifdef PULSE_GEN_RAMP_EN
            i_d[k] = apply_ramp(scale_sample(amp_q, sin_lut(lane_ph[k] + 6'd16)), ramp_s);
            q_d[k] = apply_ramp(scale_sample(amp_q, sin_lut(lane_ph[k])), ramp_s);
`else
            i_d[k] = scale_sample(amp_q, sin_lut(lane_ph[k] + 6'd16));
            q_d[k] = scale_sample(amp_q, sin_lut(lane_ph[k]));
`endif
            if (!play) begin
                i_d[k] = '0;
                q_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            amp_q   <= '0;
            base_q  <= '0;
            valid_q <= 1'b0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                i_q[k] <= '0;
                q_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            step_q  <= step_d;
            amp_q   <= amp_d;
            base_q  <= base_d;
            valid_q <= play;
            trig_q  <= play && (cnt_q == len_q);
            done_q  <= (state_q == FINISH);
            for (int k = 0; k < 5; k++) begin
                i_q[k] <= i_d[k];
                q_q[k] <= q_d[k];
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign trig_out      = trig_q;
    assign samples_valid = valid_q;
    assign done          = done_q;
    assign data0_out_0   = i_q[0];
    assign data0_out_1   = i_q[1];
    assign data0_out_2   = i_q[2];
    assign data0_out_3   = i_q[3];
    assign data0_out_4   = i_q[4];
    assign data1_out_0   = q_q[0];
    assign data1_out_1   = q_q[1];
    assign data1_out_2   = q_q[2];
    assign data1_out_3   = q_q[3];
    assign data1_out_4   = q_q[4];

endmodule

// File: doc/readout_pulse_gen.md
READOUT_PULSE_GEN -- requirements
Module: readout_pulse_gen

Interface
REQ-001 Parameter RAMP_SHIFT, default 3, meaning: ramp length is 2^RAMP_SHIFT cycles; used only when PULSE_GEN_RAMP_EN is defined.
REQ-002 clk100  in  1  sole clock; all logic is rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to play one pulse.
REQ-005 pulse_length  in  11  number of valid output cycles (5 samples per lane group per cycle).
REQ-006 delay_cycles  in  10  idle cycles between start acceptance and playback.
REQ-007 freq_step  in  6  phase increment per sample, in units of 1/64 turn.
REQ-008 amplitude  in  15  unsigned peak amplitude, 0..32767.
REQ-009 busy  out  1  high from start acceptance until done.
REQ-010 trig_out  out  1  one-cycle pulse coincident with the first valid sample.
REQ-011 samples_valid  out  1  data outputs carry pulse samples.
REQ-012 data0_out_0..data0_out_4  out  16 each  signed I samples; lane 0 is the earliest in time.
REQ-013 data1_out_0..data1_out_4  out  16 each  signed Q samples; same lane ordering.
REQ-014 done  out  1  one-cycle pulse the cycle after the last valid sample.

Function
REQ-015 FSM states are IDLE, DELAY, PLAY and FINISH; reset enters IDLE.
- IDLE + start: latch pulse_length, delay_cycles, freq_step and amplitude; assert busy; go to DELAY if delay_cycles > 0, else PLAY.
- DELAY: remain exactly delay_cycles cycles, then go to PLAY.
- PLAY: remain exactly pulse_length cycles, then go to FINISH.
- FINISH: lasts one cycle, then returns to IDLE.
REQ-016 The data path shall be one registered stage, so samples_valid is high for exactly pulse_length consecutive cycles, starting the cycle after PLAY is entered.
REQ-017 The first valid cycle shall occur delay_cycles+2 cycles after the edge that samples start.
REQ-018 start shall be ignored while busy; inputs changing after latch shall have no effect on a pulse in progress.
REQ-019 pulse_length = 0: PLAY lasts 0 cycles, no samples_valid and no trig_out; done still pulses once, delay_cycles+2 cycles after start.
REQ-020 Phase base shall be 0 at pulse start and advance by 5*freq_step per cycle, modulo 64; lane k phase = base + k*freq_step, modulo 64.
REQ-021 Sine LUT: 64 entries, signed 16-bit, full scale 32767; I uses cos(phase) and Q uses sin(phase).
REQ-022 Sample value = (amplitude * LUT) >>> 15, computed with a signed 32-bit product and truncated to 16 bits; no saturation is required because the range cannot overflow.
REQ-023 When samples_valid is low, all data outputs shall be 0.
REQ-024 done shall pulse in the cycle after the last valid sample; busy shall fall in the same cycle as done.

Reset
REQ-025 Reset shall force IDLE, with busy, trig_out, samples_valid, done and all data outputs 0, and clear the counters and phase base.
REQ-026 Reset mid-pulse shall abort immediately with no done pulse; start is accepted on the first cycle after reset deasserts.

Configuration
REQ-027 Macro PULSE_GEN_RAMP_EN: when defined, each sample is multiplied by s and then >>> RAMP_SHIFT.
- s = min(n+1, pulse_length-n, 2^RAMP_SHIFT), where n is the 0-based cycle index within PLAY.
- The ramp is applied after the REQ-022 scaling.
REQ-028 When PULSE_GEN_RAMP_EN is undefined, the envelope is rectangular and the ramp logic is absent.

Verification
REQ-029 amplitude=16384, freq_step=0, pulse_length=4, delay_cycles=0, macro off:
- valid for 4 cycles, starting 2 cycles after start.
- all data0 lanes = 16383, all data1 lanes = 0.
- trig_out on the first valid cycle; done 1 cycle after the last valid cycle.
REQ-030 freq_step=16 (quarter turn), amplitude=32767: cycle 0 lane phases are 0, 16, 32, 48, 0, giving I lanes = 32766, 0, -32767, 0, 32766; cycle 1 starts at phase 16.
REQ-031 delay_cycles=10, pulse_length=3: first valid 12 cycles after start; a second start issued mid-pulse is ignored and busy stays high throughout.
REQ-032 pulse_length=0, delay_cycles=2: no valid and no trig_out; done 4 cycles after start.
REQ-033 Reset asserted on the 2nd PLAY cycle:
- all outputs are 0 on the next cycle and done never pulses.
- a new start accepted after reset plays correctly from phase 0.
REQ-034 Macro on, RAMP_SHIFT=3, pulse_length=20, freq_step=0, amplitude=16384: I lane values per cycle are 2047, 4095, ... 16383 (cycles 7-12), ... 2047 (cycle 19).
